// File: rtl/parity_chk_pkg.sv
// Shared types and constants for the XOR-parity receive checker.
package parity_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator: clear has priority over load, load over enable.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= bit_in;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame deserialiser with XOR parity check (LSB first, parity bit last).
// Optional saturating error counter on port err_cnt when ERR_CNT_EN is defined.
module parity_frame_checker
  import parity_chk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_err,
  output logic              busy
`ifdef ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int   CNT_W   = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic              shift_en;
  logic              acc_clr, acc_load, acc_en, acc;
  logic              frame_done;
  logic              err_bit;
  logic              start;

  assign start   = in_valid & in_start;
  assign err_bit = acc ^ in_bit ^ ODD_BIT;
  assign busy    = (state_q != IDLE);

  parity_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .load   (acc_load),
    .en     (acc_en),
    .bit_in (in_bit),
    .acc    (acc)
  );

  // Bits enter at the MSB and walk down, so the first received lands in bit 0.
  always_comb begin
    shift_nxt = '0;
    for (int i = 0; i < DATA_W - 1; i++) begin
      shift_nxt[i] = shift_q[i+1];
    end
    shift_nxt[DATA_W-1] = in_bit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en   = 1'b0;
    acc_clr    = 1'b0;
    acc_load   = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;
    if (start) begin
      // A start bit always opens a new frame, silently dropping any partial one.
      shift_en = 1'b1;
      acc_load = 1'b1;
      cnt_d    = CNT_W'(1);
      state_d  = (DATA_W == 1) ? PARITY : DATA;
    end else if (in_valid) begin
      case (state_q)
        DATA: begin
          shift_en = 1'b1;
          acc_en   = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(DATA_W)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          frame_done = 1'b1;
          acc_clr    = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= frame_done;
      if (shift_en) begin
        shift_q <= shift_nxt;
      end
      if (frame_done) begin
        out_data <= shift_q;
        out_err  <= err_bit;
      end
    end
  end

`ifdef ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_err) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=8, even parity); covers err_cnt when ERR_CNT_EN is defined.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_start = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_err;
  logic       busy;
`ifdef ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int exp_errs = 0;

  parity_frame_checker #(.DATA_W(8), .PARITY_ODD(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_start  (in_start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_err   (out_err),
    .busy      (busy)
`ifdef ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) pulses++;
  end

  task automatic drive(input logic v, input logic b, input logic s);
    in_valid = v;
    in_bit   = b;
    in_start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) drive(1'b1, d[i], i == 0);
    drive(1'b1, p, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef ERR_CNT_EN
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
`endif
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_ignore();
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_good_frame();
    logic [7:0] d;
    int p0;
    d  = 8'hA5;
    p0 = pulses;
    for (int i = 0; i < 8; i++) drive(1'b1, d[i], i == 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL good_busy: got %b want 1", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL good_early_valid: got %b want 0", out_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL good_data: got %h want a5", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL good_err: got %b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_after: got %b want 0", busy); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL good_pulse_len: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL good_hold: got %h want a5", out_data); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL good_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hA5, 1'b1);
    exp_errs++;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bad_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL bad_data: got %h want a5", out_data); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL bad_err: got %b want 1", out_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL bad_err_hold: got %b want 1", out_err); end
`ifdef ERR_CNT_EN
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL bad_errcnt: got %0d want 1", err_cnt); end
`endif
    // 8'h01 has one set bit: parity 1 is correct for even parity.
    send_frame(8'h01, 1'b1);
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL odd_ones_err: got %b want 0", out_err); end
    n_cmp++; if (out_data !== 8'h01) begin n_bad++; $display("FAIL odd_ones_data: got %h want 01", out_data); end
    send_frame(8'h80, 1'b0);
    exp_errs++;
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL msb_err: got %b want 1", out_err); end
    n_cmp++; if (out_data !== 8'h80) begin n_bad++; $display("FAIL msb_data: got %h want 80", out_data); end
    drive(1'b0, 1'b0, 1'b0);
`ifdef ERR_CNT_EN
    n_cmp++; if (err_cnt !== 8'(exp_errs)) begin n_bad++; $display("FAIL errcnt_two: got %0d want %0d", err_cnt, exp_errs); end
`endif
  endtask

  task automatic test_stall();
    logic [7:0] d;
    int n;
    d = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d[i], i == 0);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1 (bit %0d)", busy, i); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid: got %b want 0 (bit %0d)", out_valid, i); end
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h3C) begin n_bad++; $display("FAIL stall_data: got %h want 3c", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL stall_err: got %b want 0", out_err); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b0);
    n_cmp++; if (out_data !== 8'h0F) begin n_bad++; $display("FAIL abort_data: got %h want 0f", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL abort_err: got %b want 0", out_err); end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL abort_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    for (int i = 0; i < 4; i++) drive(1'b1, d[i], i == 0);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    exp_errs = 0;
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
`ifdef ERR_CNT_EN
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_errcnt: got %0d want 0", err_cnt); end
`endif
    rst_n = 1'b1;
    send_frame(8'hFF, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hFF) begin n_bad++; $display("FAIL rstmid_next_data: got %h want ff", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_next_err: got %b want 0", out_err); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic p;
    int p0;
    p0 = pulses;
    for (int k = 0; k < 300; k++) begin
      d = 8'(k * 37 + 3);
      p = ~(^d);
      send_frame(d, p);
      if (exp_errs < 255) exp_errs++;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1 (frame %0d)", out_valid, k); end
      n_cmp++; if (out_data !== d) begin n_bad++; $display("FAIL b2b_data: got %h want %h (frame %0d)", out_data, d, k); end
      n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL b2b_err: got %b want 1 (frame %0d)", out_err, k); end
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (pulses - p0 !== 300) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 300", pulses - p0); end
`ifdef ERR_CNT_EN
    n_cmp++; if (err_cnt !== 8'(exp_errs)) begin n_bad++; $display("FAIL b2b_errcnt: got %0d want %0d", err_cnt, exp_errs); end
    n_cmp++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL b2b_saturate: got %0d want 255", err_cnt); end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_ignore();
    test_good_frame();
    test_bad_parity();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
